spi_slave_rx: RTL and testbench
===============================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer flip-flop count on nCS/SCK/MOSI (legal 2..3).
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port nCS  input  1  SPI chip select from master, active-low, asynchronous.
REQ-005 SHALL have port SCK  input  1  SPI clock from master, asynchronous.
REQ-006 SHALL have port MOSI  input  1  SPI data from master, asynchronous.
REQ-007 SHALL have port MISO  output  1  SPI data to master.
REQ-008 SHALL have port rx_data  output  8  received byte at head of receive store.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unread byte.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts rx_data; pop when rx_valid&rx_ready.
REQ-011 SHALL have port tx_data  input  8  byte to return on MISO.
REQ-012 SHALL have port tx_load  input  1  one-cycle strobe writing tx_data into tx holding register.
REQ-013 SHALL have port overrun  output  1  sticky: received byte dropped because store full.
REQ-014 SHALL have port busy  output  1  synchronized nCS low (frame active).

Function
REQ-015 SHALL pass nCS, SCK, MOSI through SYNC_STAGES flip-flops; edges detected from last two stages; pin-to-detect latency SYNC_STAGES+1 CLK.
REQ-016 SHALL implement SPI mode 0, MSB first: sample MOSI on detected SCK rise, shift MISO on detected SCK fall.
REQ-017 SHALL require each SCK high/low phase >= SYNC_STAGES+2 CLK; shorter phases undefined.
REQ-018 SHALL use two states: IDLE (nCS high) and SHIFT (nCS low); IDLE->SHIFT on synchronized nCS fall, SHIFT->IDLE on synchronized nCS rise.
REQ-019 On IDLE->SHIFT SHALL clear 3-bit bit counter, copy tx holding register into tx shift register, drive MISO = its bit 7 same cycle.
REQ-020 SHALL, on 8th sampled rise, push assembled byte into receive store one CLK later, wrap bit counter to 0, and reload tx shift register from holding register at next SCK fall.
REQ-021 SHALL discard a partial byte (<8 bits) when nCS rises; no push, no overrun change.
REQ-022 SHALL ignore SCK edges while nCS synchronized high.
REQ-023 tx_load SHALL update holding register any time; mid-byte load takes effect at next byte boundary; holding register retained across frames.
REQ-024 Push with store full and no simultaneous pop SHALL drop the byte and set overrun; push with full store and simultaneous pop SHALL succeed.
REQ-025 Push to empty store SHALL assert rx_valid the following cycle; rx_data stable while rx_valid high and rx_ready low.
REQ-026 MISO SHALL hold last driven value in IDLE.

Reset
REQ-027 RST SHALL force: state IDLE, synchronizers to nCS=1/SCK=0/MOSI=0, bit counter 0, shift registers 0x00, tx holding 0x00, store empty, rx_data 0x00, rx_valid 0, overrun 0, busy 0, MISO 0.
REQ-028 RST mid-frame SHALL abort the frame; after release a new frame starts only on a fresh nCS fall.

Configuration
REQ-029 With SPI_SLAVE_RX_FIFO_EN defined, receive store SHALL be a 4-entry FIFO (full at 4, first-in first-out).
REQ-030 Without SPI_SLAVE_RX_FIFO_EN, receive store SHALL be a single holding register (full when rx_valid high); all other behaviour identical.

Verification
REQ-031 Frame MOSI=0xA5, tx_load 0x3C beforehand, rx_ready=1 -> rx_data 0xA5 one rx_valid pulse; MISO sequence 0,0,1,1,1,1,0,0.
REQ-032 Three bytes 0x11,0x22,0x33 in one frame, rx_ready=0 -> FIFO build: all three queued, overrun 0; single-register build: 0x11 held, overrun 1.
REQ-033 nCS raised after 5 bits of 0xFF, then full frame 0x81 -> only 0x81 received, bit counter restarted.
REQ-034 rx_ready asserted in exact cycle of push into full store -> no overrun, new byte appears next.
REQ-035 RST pulsed after 4 bits -> all outputs at reset values; next frame 0x5A received correctly.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver with MISO return path and a receive store.
// Define SPI_SLAVE_RX_FIFO_EN for a 4-entry FIFO store; otherwise a single holding register.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       nCS,
  input  logic       SCK,
  input  logic       MOSI,
  output logic       MISO,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;
  logic [1:0]             fill_cnt;
  logic                   armed;
  logic                   start;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift, tx_shift, tx_hold, push_byte;
  logic                   push_req, reload;
  logic                   pop, full, accept;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], nCS};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign cs_fall  =  cs_sync[SYNC_STAGES-1]  & ~cs_sync[SYNC_STAGES-2];
  assign cs_rise  = ~cs_sync[SYNC_STAGES-1]  &  cs_sync[SYNC_STAGES-2];
  assign sck_rise = ~sck_sync[SYNC_STAGES-1] &  sck_sync[SYNC_STAGES-2];
  assign sck_fall =  sck_sync[SYNC_STAGES-1] & ~sck_sync[SYNC_STAGES-2];

  // After reset the synchronizer reads nCS=1 regardless of the pin, so a frame
  // may only start once the real pin level has been seen high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fill_cnt <= '0;
      armed    <= 1'b0;
    end else if (fill_cnt != 2'(SYNC_STAGES)) begin
      fill_cnt <= fill_cnt + 2'd1;
    end else if (cs_sync[SYNC_STAGES-1]) begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_next = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_hold   <= '0;
      push_byte <= '0;
      push_req  <= 1'b0;
      reload    <= 1'b0;
      MISO      <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (tx_load) tx_hold <= tx_data;
      if (start) begin
        bit_cnt  <= '0;
        tx_shift <= tx_hold;
        MISO     <= tx_hold[7];
        reload   <= 1'b0;
      end else if (state == SHIFT && !cs_rise) begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_sync[SYNC_STAGES-1]};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            push_req  <= 1'b1;
            push_byte <= {rx_shift[6:0], mosi_sync[SYNC_STAGES-1]};
            reload    <= 1'b1;
          end
        end else if (sck_fall) begin
          // The byte boundary fall picks up whatever the holding register has now.
          if (reload) begin
            tx_shift <= tx_hold;
            MISO     <= tx_hold[7];
            reload   <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            MISO     <= tx_shift[6];
          end
        end
      end
    end
  end

  assign pop    = rx_valid && rx_ready;
  assign accept = push_req && (!full || pop);

`ifdef SPI_SLAVE_RX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  assign full     = (count == 3'd4);
  assign rx_valid = (count != 3'd0);
  assign rx_data  = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_byte;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (accept && !pop)      count <= count + 3'd1;
      else if (!accept && pop) count <= count - 3'd1;
      if (push_req && !accept) overrun <= 1'b1;
    end
  end
`else
  assign full = rx_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (accept) begin
        rx_data  <= push_byte;
        rx_valid <= 1'b1;
      end else if (pop) begin
        rx_valid <= 1'b0;
      end
      if (push_req && !accept) overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: randomized SPI frames, queue-based reference of the receive store.
module tb_spi_slave_rx;

  localparam int PH = 8;
`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST, nCS, SCK, MOSI, MISO;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_load, overrun, busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int         model_cnt;
  bit         steady;
  bit         pop_at_push;
  logic [7:0] tx_hold_m;
  logic [7:0] frame_data [8];

  spi_slave_rx #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .nCS(nCS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_load(tx_load), .overrun(overrun), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reference store: a byte is kept if the consumer is draining, a pop coincides,
  // or there is room; otherwise it is lost.
  task automatic modelPush(input logic [7:0] b);
    if (steady || pop_at_push) begin
      exp_q.push_back(b);
    end else if (model_cnt < CAP) begin
      exp_q.push_back(b);
      model_cnt++;
    end
  endtask

  // Scoreboard monitor: every handshake the DUT presents must match the oldest expected byte.
  always @(negedge CLK) begin
    if (RST === 1'b0 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rx_unexpected: got 0x%0h, required no byte", rx_data);
      end else begin
        checkOutput("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic loadTx(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    tx_hold_m = v;
  endtask

  task automatic doReset();
    RST = 1'b1;
    tick(3);
    RST = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    tx_hold_m = 8'h00;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    checkOutput({tag, "_rx_data"},  32'(rx_data),  32'd0);
    checkOutput({tag, "_overrun"},  32'(overrun),  32'd0);
    checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    checkOutput({tag, "_miso"},     32'(MISO),     32'd0);
  endtask

  // One frame: nbytes full bytes from frame_data, then part_bits of one more byte.
  task automatic applyStimulus(input int nbytes, input int part_bits, input bit mid_load,
                               input logic [7:0] mid_val);
    logic [7:0] cur;
    int total, nb;
    cur = tx_hold_m;
    total = nbytes + ((part_bits > 0) ? 1 : 0);
    nCS = 1'b0;
    tick(PH);
    checkOutput("busy_frame", 32'(busy), 32'd1);
    for (int b = 0; b < total; b++) begin
      nb = (b < nbytes) ? 8 : part_bits;
      for (int i = 0; i < nb; i++) begin
        MOSI = frame_data[b][7-i];
        tick(PH);
        checkOutput("miso_bit", 32'(MISO), 32'(cur[7-i]));
        SCK = 1'b1;
        if (i == 7) modelPush(frame_data[b]);
        if (mid_load && b == 0 && i == 3) begin
          loadTx(mid_val);
          tick(PH - 1);
        end else begin
          tick(PH);
        end
        SCK = 1'b0;
        if (i == 7) cur = tx_hold_m;
      end
    end
    tick(PH);
    nCS = 1'b1;
    tick(PH * 2);
    if (part_bits == 0 && nbytes > 0)
      checkOutput("miso_idle_hold", 32'(MISO), 32'(cur[7]));
  endtask

  task automatic drain(input string tag);
    rx_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick(1);
    tick(4);
    checkOutput({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    rx_ready = 1'b0;
    model_cnt = 0;
  endtask

  task automatic popAtPush();
    int k;
    for (k = 0; k < 2000 && dut.push_req !== 1'b1; k++) tick(1);
    if (k == 2000) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_wait: got timeout, required a push");
    end else begin
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 1ms");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b1; nCS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
    rx_ready = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    steady = 1'b0; pop_at_push = 1'b0; model_cnt = 0; tx_hold_m = 8'h00;
    tick(4);
    doReset();
    tick(6);
    checkReset("reset");

    $display("[TB] single byte 0xA5 with tx 0x3C");
    loadTx(8'h3C);
    rx_ready = 1'b1;
    steady = 1'b1;
    frame_data[0] = 8'hA5;
    applyStimulus(1, 0, 1'b0, 8'h00);
    tick(10);
    checkOutput("a5_consumed", 32'(exp_q.size()), 32'd0);

    $display("[TB] partial 0xFF then 0x81");
    frame_data[0] = 8'hFF;
    applyStimulus(0, 5, 1'b0, 8'h00);
    frame_data[0] = 8'h81;
    applyStimulus(1, 0, 1'b0, 8'h00);
    tick(10);
    checkOutput("partial_consumed", 32'(exp_q.size()), 32'd0);
    checkOutput("partial_overrun", 32'(overrun), 32'd0);

    $display("[TB] random frames");
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) frame_data[j] = 8'($urandom);
      loadTx(8'($urandom));
      applyStimulus(n, 0, 1'($urandom_range(0, 1)), 8'($urandom));
      tick(10);
      checkOutput("rand_consumed", 32'(exp_q.size()), 32'd0);
      checkOutput("rand_overrun", 32'(overrun), 32'd0);
    end

    $display("[TB] pop coinciding with push into full store");
    rx_ready = 1'b0;
    steady = 1'b0;
    model_cnt = 0;
    for (int j = 0; j < CAP; j++) frame_data[j] = 8'($urandom);
    applyStimulus(CAP, 0, 1'b0, 8'h00);
    checkOutput("full_valid", 32'(rx_valid), 32'd1);
    checkOutput("full_overrun", 32'(overrun), 32'd0);
    frame_data[0] = 8'($urandom);
    pop_at_push = 1'b1;
    fork
      applyStimulus(1, 0, 1'b0, 8'h00);
      popAtPush();
    join
    pop_at_push = 1'b0;
    checkOutput("simul_overrun", 32'(overrun), 32'd0);
    drain("simul");

    $display("[TB] three bytes with consumer stalled");
    frame_data[0] = 8'h11; frame_data[1] = 8'h22; frame_data[2] = 8'h33;
    applyStimulus(3, 0, 1'b0, 8'h00);
    tick(5);
    checkOutput("stall_overrun", 32'(overrun), (CAP < 3) ? 32'd1 : 32'd0);
    drain("stall");

    $display("[TB] reset in the middle of a frame");
    rx_ready = 1'b1;
    steady = 1'b1;
    nCS = 1'b0;
    tick(PH);
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'($urandom_range(0, 1));
      tick(PH);
      SCK = 1'b1;
      tick(PH);
      SCK = 1'b0;
    end
    doReset();
    tick(10);
    checkReset("midreset");
    nCS = 1'b1;
    tick(PH * 2);
    frame_data[0] = 8'h5A;
    applyStimulus(1, 0, 1'b0, 8'h00);
    tick(10);
    checkOutput("after_reset_consumed", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
